// File: rtl/tt_shifter_pkg.sv
// Shared constants, op encoding and control-field layout for the tt_shifter tile.
package tt_shifter_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SHW   = 3;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_SRA  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_LDSL = 3'b111
    } op_e;

    localparam int unsigned SHAMT_LSB = 0;
    localparam int unsigned OP_LSB    = 3;
    localparam int unsigned FILL_BIT  = 6;

    localparam logic [7:0] UIO_OE_VAL = 8'h80;

endpackage

// File: rtl/tt_shifter_core.sv
// Combinational log2 barrel shifter/rotator: one mux stage per shamt bit.
module shifter_core
    import tt_shifter_pkg::*;
(
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   shamt,
    input  op_e              op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [SHW:0][WIDTH-1:0] stage;
    logic                    fill_bit;

    // SRA keeps replicating the original sign; the sign bit survives every stage.
    always_comb begin
        fill_bit = 1'b0;
        case (op)
            OP_SLL, OP_SRL: fill_bit = fill;
            OP_SRA:         fill_bit = operand[WIDTH-1];
            default:        fill_bit = 1'b0;
        endcase
    end

    assign stage[0] = operand;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned N = 1 << k;
        logic [WIDTH-1:0] shifted;

        always_comb begin
            shifted = stage[k];
            case (op)
                OP_SLL, OP_LDSL: shifted = {stage[k][WIDTH-1-N:0], {N{fill_bit}}};
                OP_SRL, OP_SRA:  shifted = {{N{fill_bit}}, stage[k][WIDTH-1:N]};
                OP_ROL:          shifted = {stage[k][WIDTH-1-N:0], stage[k][WIDTH-1:WIDTH-N]};
                OP_ROR:          shifted = {stage[k][N-1:0], stage[k][WIDTH-1:N]};
                default:         shifted = stage[k];
            endcase
        end

        assign stage[k+1] = shamt[k] ? shifted : stage[k];
    end

    assign result = stage[SHW];

endmodule

// File: rtl/tt_shifter.sv
// TinyTapeout tile: 8-bit registered shifter/rotator with a zero flag on uio[7].
module tt_shifter
    import tt_shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] next_val;
    logic [SHW-1:0]   shamt;
    op_e              op;
    logic             fill;
    logic             unused_ctrl;

    assign shamt = uio_in[SHAMT_LSB +: SHW];
    assign op    = op_e'(uio_in[OP_LSB +: $bits(op_e)]);
    assign fill  = uio_in[FILL_BIT];

    assign unused_ctrl = &{1'b0, uio_in[7]};

    // Load variants take the pin data as operand; everything else works in place.
    assign operand = (op == OP_LOAD || op == OP_LDSL) ? ui_in : data_q;

    shifter_core u_core (
        .operand (operand),
        .shamt   (shamt),
        .op      (op),
        .fill    (fill),
        .result  (next_val)
    );

    // rst_n is active-high despite its name; the pin name is fixed by the tile wrapper.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_q <= '0;
        end else if (ena) begin
            data_q <= next_val;
        end
    end

    assign uo_out  = data_q;
    assign uio_out = {(data_q == '0), 7'b0};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_shifter.sv
// Scoreboard bench for tt_shifter: directed spec vectors plus a randomized run with a mid-stream reset.
module tb_tt_shifter;
    import tt_shifter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    tt_shifter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl(input logic [2:0] op, input int s, input bit f);
        logic [7:0] c;
        logic [31:0] sv;
        sv = s;
        c = '0;
        c[2:0] = sv[2:0];
        c[5:3] = op;
        c[6] = f;
        return c;
    endfunction

    // Behavioural reference written from the op table, independent of the barrel structure.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r, input logic e,
                                            input logic [7:0] ui, input logic [7:0] c);
        logic [2:0]  s;
        logic        f;
        logic [7:0]  m;
        logic [15:0] t;
        s = c[2:0];
        f = c[6];
        if (r) return 8'h00;
        if (!e) return cur;
        case (c[5:3])
            3'd0: return cur;
            3'd1: return ui;
            3'd2: begin m = 8'hFF << s; return (cur << s) | (f ? ~m : 8'h00); end
            3'd3: begin m = 8'hFF >> s; return (cur >> s) | (f ? ~m : 8'h00); end
            3'd4: return 8'($signed(cur) >>> s);
            3'd5: begin t = {cur, cur} << s; return t[15:8]; end
            3'd6: begin t = {cur, cur} >> s; return t[7:0]; end
            default: return ui << s;
        endcase
    endfunction

    task automatic apply(input logic r, input logic e, input logic [7:0] ui,
                         input logic [7:0] c, input logic [7:0] exp, input string name);
        exp_t x;
        rst_n  = r;
        ena    = e;
        ui_in  = ui;
        uio_in = c;
        x.data = exp;
        x.name = name;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 8'hFF, ctl(OP_LOAD, 0, 0), 8'h00, "reset");
            if (sb_q.size() == 0) begin bad++; total++; $display("FAIL reset scoreboard empty"); continue; end
            e = sb_q.pop_front();
            total++;
            if (uo_out !== e.data) begin bad++; $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.data); end
            total++;
            if (uio_out !== 8'h80) begin bad++; $display("FAIL %s uio_out got=%h exp=80", e.name, uio_out); end
            total++;
            if (uio_oe !== 8'h80) begin bad++; $display("FAIL %s uio_oe got=%h exp=80", e.name, uio_oe); end
        end
    endtask

    task automatic test_load_hold();
        exp_t e;
        apply(1'b0, 1'b1, 8'hA5, ctl(OP_LOAD, 5, 1), 8'hA5, "load_a5");
        apply(1'b0, 1'b0, 8'h3C, ctl(OP_LOAD, 0, 0), 8'hA5, "ena0_hold");
        apply(1'b0, 1'b1, 8'h3C, ctl(OP_HOLD, 3, 1), 8'hA5, "op_hold");
        apply(1'b0, 1'b1, 8'h3C, 8'h80 | ctl(OP_HOLD, 0, 0), 8'hA5, "bit7_ignored");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (uo_out !== e.data) begin bad++; $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.data); end
        end
        total++;
        if (uio_out[7] !== 1'b0) begin bad++; $display("FAIL load_zero_flag got=%b exp=0", uio_out[7]); end
    endtask

    task automatic test_shifts();
        exp_t e;
        logic [7:0] c [14];
        logic [7:0] u [14];
        logic [7:0] x [14];
        string      n [14];
        c[0]  = ctl(OP_LOAD, 0, 0); u[0]  = 8'hA5; x[0]  = 8'hA5; n[0]  = "reload_a5";
        c[1]  = ctl(OP_SLL, 3, 1);  u[1]  = 8'h00; x[1]  = 8'h2F; n[1]  = "sll3_f1";
        c[2]  = ctl(OP_LOAD, 0, 0); u[2]  = 8'hA5; x[2]  = 8'hA5; n[2]  = "reload_a5";
        c[3]  = ctl(OP_SRL, 2, 0);  u[3]  = 8'hFF; x[3]  = 8'h29; n[3]  = "srl2_f0";
        c[4]  = ctl(OP_LOAD, 0, 0); u[4]  = 8'hA5; x[4]  = 8'hA5; n[4]  = "reload_a5";
        c[5]  = ctl(OP_SRL, 7, 0);  u[5]  = 8'hFF; x[5]  = 8'h01; n[5]  = "srl7_f0";
        c[6]  = ctl(OP_LOAD, 0, 0); u[6]  = 8'h90; x[6]  = 8'h90; n[6]  = "load_90";
        c[7]  = ctl(OP_SRA, 3, 0);  u[7]  = 8'h00; x[7]  = 8'hF2; n[7]  = "sra3";
        c[8]  = ctl(OP_LOAD, 0, 0); u[8]  = 8'h81; x[8]  = 8'h81; n[8]  = "load_81";
        c[9]  = ctl(OP_ROL, 1, 1);  u[9]  = 8'h00; x[9]  = 8'h03; n[9]  = "rol1";
        c[10] = ctl(OP_ROR, 4, 1);  u[10] = 8'h00; x[10] = 8'h30; n[10] = "ror4";
        c[11] = ctl(OP_LOAD, 0, 0); u[11] = 8'h5A; x[11] = 8'h5A; n[11] = "load_5a";
        c[12] = ctl(OP_ROL, 0, 1);  u[12] = 8'h00; x[12] = 8'h5A; n[12] = "rol0";
        c[13] = ctl(OP_LDSL, 7, 1); u[13] = 8'h81; x[13] = 8'h80; n[13] = "ldsl7";
        for (int i = 0; i < 14; i++) begin
            apply(1'b0, 1'b1, u[i], c[i], x[i], n[i]);
            e = sb_q.pop_front();
            total++;
            if (uo_out !== e.data) begin bad++; $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.data); end
        end
        apply(1'b0, 1'b1, 8'hFF, ctl(OP_SLL, 1, 0), 8'h00, "sll1_to_zero");
        e = sb_q.pop_front();
        total++;
        if (uo_out !== e.data) begin bad++; $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.data); end
        total++;
        if (uio_out !== 8'h80) begin bad++; $display("FAIL zero_flag uio_out got=%h exp=80", uio_out); end
    endtask

    task automatic test_random_reset();
        exp_t       e;
        logic [7:0] model;
        logic [7:0] ui, c;
        logic       r, en;
        model = uo_out === 8'h00 ? 8'h00 : 8'h00;
        apply(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "rand_pre_reset");
        e = sb_q.pop_front();
        total++;
        if (uo_out !== e.data) begin bad++; $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.data); end
        for (int i = 0; i < 100; i++) begin
            ui = 8'($urandom);
            c  = 8'($urandom);
            if (i % 4 == 0) c[5:3] = 3'd1;
            en = ($urandom_range(0, 9) != 0);
            r  = (i == 50);
            model = ref_next(model, r, en, ui, c);
            apply(r, en, ui, c, model, r ? "rand_reset" : "rand_step");
            e = sb_q.pop_front();
            total++;
            if (uo_out !== e.data) begin bad++; $display("FAIL %s cyc=%0d uo_out got=%h exp=%h", e.name, i, uo_out, e.data); end
            total++;
            if (uio_out !== {(e.data == 8'h00), 7'b0}) begin
                bad++; $display("FAIL %s cyc=%0d uio_out got=%h exp_data=%h", e.name, i, uio_out, e.data);
            end
            if (r) begin
                total++;
                if (uo_out !== 8'h00) begin bad++; $display("FAIL mid_reset uo_out got=%h exp=00", uo_out); end
            end
        end
        total++;
        if (uio_oe !== 8'h80) begin bad++; $display("FAIL rand_uio_oe got=%h exp=80", uio_oe); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_shifts();
        test_random_reset();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_shifter.md
Name: tt_shifter

Overview:
- 8-bit registered shifter/rotator in the standard TinyTapeout user-tile wrapper pinout.
- An 8-bit data register is loaded from ui_in, or shifted/rotated in place by a 0..7 amount each enabled clock.
- Register contents drive uo_out; a zero flag drives one bidirectional pin.
- Sits directly under the chip-level tile mux; no other logic is in the tile.

Parameters:
- WIDTH, 8, data register width; fixed by the TT pinout, and only 8 is supported.
- SHW, 3, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset: synchronous, active-high (1 = reset). The name is kept for TT pin compatibility.
- ena  input  1  tile enable; 0 = register holds.
- ui_in  input  8  load data.
- uio_in  input  8  control: [2:0] shamt, [5:3] op, [6] fill bit, [7] unused.
- uo_out  output  8  current data register value.
- uio_out  output  8  [7] zero flag (register == 0); [6:0] tied 0.
- uio_oe  output  8  constant 8'h80: bit 7 is an output, bits 6:0 are inputs.

Behaviour:
- Reset: sampled on the rising clk edge when rst_n=1.
  - Register clears to 8'h00, so uo_out=8'h00 and uio_out=8'h80 from the first edge.
  - Reset has priority over ena and op.
- Update: when ena=1 and reset is not asserted, the register updates on the rising edge per op.
  - Result is visible on uo_out in the same cycle after the edge (1-cycle latency).
  - There is no handshake.
- Op encoding (uio_in[5:3]); s = shamt, f = fill bit:
  - 000 HOLD: register unchanged.
  - 001 LOAD: reg <= ui_in; shamt and fill ignored.
  - 010 SLL: reg <= reg << s; vacated low s bits = f.
  - 011 SRL: reg <= reg >> s; vacated high s bits = f.
  - 100 SRA: arithmetic right shift; vacated high bits = old reg[7]; f ignored.
  - 101 ROL: rotate left by s.
  - 110 ROR: rotate right by s.
  - 111 LDSL: reg <= ui_in << s with zero fill (load-and-shift in one cycle).
- Shift amount boundaries:
  - s=0 leaves shift/rotate results equal to the input operand.
  - s=7 is the maximum. No 8-position shift exists; shamt is never wider than 3 bits.
- ena=0: register holds regardless of op, ui_in and uio_in.
- Zero flag: uio_out[7] is combinational from the register, 1 when reg==8'h00. It updates with the register, with no additional delay.
- Outputs: uo_out and uio_out are driven only from the register and constants. There is no combinational path from ui_in/uio_in to any output.
- uio_in[7] has no effect. uio_oe never changes, including during reset.
- Reset mid-operation: the pending op is discarded and the register is 0 after that edge.

Decomposition:
- Package tt_shifter_pkg holds:
  - WIDTH and SHW constants.
  - op_e enum: OP_HOLD, OP_LOAD, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_LDSL.
  - Control-field bit positions (SHAMT_LSB, OP_LSB, FILL_BIT).
  - UIO_OE_VAL = 8'h80.
- One combinational sub-module, shifter_core:
  - Inputs: operand, shamt, op, fill.
  - Output: next value, built as a log2 barrel shifter of 3 mux stages.
  - The top holds only the register, enable/reset logic, flag and pin mapping.

Test Plan:
- Reset: rst_n=1 for 2 edges with ena=1, op=LOAD, ui_in=8'hFF -> uo_out=8'h00, uio_out=8'h80, uio_oe=8'h80.
- Load/hold/ena:
  - LOAD ui_in=8'hA5 -> uo_out=8'hA5, uio_out[7]=0.
  - Then op=LOAD with ui_in=8'h3C and ena=0 -> stays 8'hA5.
  - Then op=HOLD with ena=1 -> stays 8'hA5.
- Logical shifts with fill, from 8'hA5:
  - SLL s=3 f=1 -> 8'h2F.
  - Reload 8'hA5; SRL s=2 f=0 -> 8'h29.
  - Reload 8'hA5; SRL s=7 f=0 -> 8'h01.
- Arithmetic/rotate:
  - From 8'h90: SRA s=3 -> 8'hF2.
  - From 8'h81: ROL s=1 -> 8'h03, then ROR s=4 -> 8'h30.
  - From 8'h5A: ROL s=0 -> 8'h5A.
- LDSL and zero flag:
  - LDSL ui_in=8'h81 s=7 -> 8'h80.
  - Then SLL s=1 f=0 -> 8'h00 with uio_out[7]=1.
- Reset mid-stream: alternate random ops for 100 cycles against a reference model, assert rst_n=1 for one edge at cycle 50 -> uo_out=8'h00 next cycle, and the model matches throughout.
